// File: rtl/seq_detector_param_pkg.sv
// Shared constants, fill-state encoding and elaboration helpers for the
// parametrised serial pattern detector.
package seq_det_pkg;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 32;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_ARMED   = 2'd2
   } fill_state_e;

   // Bits needed to hold the values 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage : seq_det_pkg

// File: rtl/seq_detector_param_if.sv
// Configuration, serial stream and status bundle of the pattern detector.
// The detector connects to the slave side, the stream source to the master side.
interface seq_detector_param_if #(
   parameter int PAT_LEN = 3,
   parameter int CNT_W   = 8
);

   logic               cfg_load;
   logic [PAT_LEN-1:0] pattern_in;
   logic               overlap_in;
   logic               in_valid;
   logic               in_bit;
   logic               count_clr;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               armed;

   modport master (
      output cfg_load,
      output pattern_in,
      output overlap_in,
      output in_valid,
      output in_bit,
      output count_clr,
      input  match,
      input  match_count,
      input  armed
   );

   modport slave (
      input  cfg_load,
      input  pattern_in,
      input  overlap_in,
      input  in_valid,
      input  in_bit,
      input  count_clr,
      output match,
      output match_count,
      output armed
   );

endinterface : seq_detector_param_if

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: clear beats increment, and the count sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a run-time pattern, selectable overlap mode,
// input qualifier and a saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int PAT_LEN = 3,
   parameter int CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_detector_param_if.slave  bus
);

   localparam int              FW        = clog2(PAT_LEN + 1);
   localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_LEN);
   localparam logic [FW-1:0]   FILL_HIT  = FW'(PAT_LEN - 1);

   if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
      $error("seq_detector_param: PAT_LEN=%0d is outside %0d..%0d",
             PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX);
   end

   logic [PAT_LEN-1:0] pat_q,   pat_d;
   logic               ovl_q,   ovl_d;
   logic [PAT_LEN-2:0] hist_q,  hist_d;
   logic [FW-1:0]      fill_q,  fill_d;
   fill_state_e        state_q, state_d;
   logic               match_q, match_d;

   logic               accept;
   logic               hit;
   logic [PAT_LEN-1:0] cand;

   // Only the newest PAT_LEN-1 bits are kept; the incoming bit completes the
   // candidate window. fill counts how many of those window bits are genuine.
   always_comb begin
      accept  = bus.in_valid && !bus.cfg_load;
      cand    = {hist_q, bus.in_bit};
      hit     = accept && (fill_q >= FILL_HIT) && (cand == pat_q);

      pat_d   = pat_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = hit;

      if (bus.cfg_load) begin
         pat_d  = bus.pattern_in;
         ovl_d  = bus.overlap_in;
         fill_d = '0;
      end else if (accept) begin
         hist_d = cand[PAT_LEN-2:0];
         if (hit) begin
            fill_d = ovl_q ? FILL_FULL : '0;
         end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FW'(1);
         end
      end

      if (fill_d == '0) begin
         state_d = ST_EMPTY;
      end else if (fill_d == FILL_FULL) begin
         state_d = ST_ARMED;
      end else begin
         state_d = ST_FILLING;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_q   <= '0;
         ovl_q   <= 1'b1;
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= ST_EMPTY;
         match_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         match_q <= match_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit),
      .clr   (bus.count_clr),
      .q     (bus.match_count)
   );

   assign bus.match = match_q;
   assign bus.armed = (state_q == ST_ARMED);

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench driving three detector configurations (3-bit, 8-bit,
// 2-bit with 2-bit counter) against hand-computed expected outputs.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] pattern_in = '0;
   logic       overlap_in = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       count_clr = 1'b0;
   int         sel = 0;

   int         vectorCount = 0;
   int         missCount = 0;

   logic       obsMatch;
   logic       obsArmed;
   int         obsCount;

   always #5 clk = ~clk;

   seq_detector_param_if #(.PAT_LEN(3), .CNT_W(8)) bus3 ();
   seq_detector_param_if #(.PAT_LEN(8), .CNT_W(8)) bus8 ();
   seq_detector_param_if #(.PAT_LEN(2), .CNT_W(2)) bus2 ();

   assign bus3.cfg_load   = cfg_load && (sel == 0);
   assign bus3.pattern_in = pattern_in[2:0];
   assign bus3.overlap_in = overlap_in;
   assign bus3.in_valid   = in_valid && (sel == 0);
   assign bus3.in_bit     = in_bit;
   assign bus3.count_clr  = count_clr && (sel == 0);

   assign bus8.cfg_load   = cfg_load && (sel == 1);
   assign bus8.pattern_in = pattern_in;
   assign bus8.overlap_in = overlap_in;
   assign bus8.in_valid   = in_valid && (sel == 1);
   assign bus8.in_bit     = in_bit;
   assign bus8.count_clr  = count_clr && (sel == 1);

   assign bus2.cfg_load   = cfg_load && (sel == 2);
   assign bus2.pattern_in = pattern_in[1:0];
   assign bus2.overlap_in = overlap_in;
   assign bus2.in_valid   = in_valid && (sel == 2);
   assign bus2.in_bit     = in_bit;
   assign bus2.count_clr  = count_clr && (sel == 2);

   seq_detector_param #(.PAT_LEN(3), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
   seq_detector_param #(.PAT_LEN(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   seq_detector_param #(.PAT_LEN(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   always_comb begin
      obsMatch = bus3.match;
      obsArmed = bus3.armed;
      obsCount = 32'(bus3.match_count);
      if (sel == 1) begin
         obsMatch = bus8.match;
         obsArmed = bus8.armed;
         obsCount = 32'(bus8.match_count);
      end else if (sel == 2) begin
         obsMatch = bus2.match;
         obsArmed = bus2.armed;
         obsCount = 32'(bus2.match_count);
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clock of stimulus; outputs are sampled 1 ns after the edge.
   task automatic applyStimulus(input logic cfg, input logic [7:0] pat, input logic ovl,
                                input logic valid, input logic b, input logic clr);
      cfg_load   = cfg;
      pattern_in = pat;
      overlap_in = ovl;
      in_valid   = valid;
      in_bit     = b;
      count_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic sendBits(input logic [31:0] bits, input int n, input logic [31:0] expMatch,
                           input logic [31:0] expArmed, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, bits[i], 1'b0);
         checkOutput($sformatf("%s match bit%0d", tag, n - i), 32'(obsMatch), 32'(expMatch[i]));
         checkOutput($sformatf("%s armed bit%0d", tag, n - i), 32'(obsArmed), 32'(expArmed[i]));
      end
   endtask

   logic [2:0] t3Bits;

   initial begin
      t3Bits = 3'b101;

      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checkOutput($sformatf("reset match dut%0d", s), 32'(obsMatch), 0);
         checkOutput($sformatf("reset armed dut%0d", s), 32'(obsArmed), 0);
         checkOutput($sformatf("reset count dut%0d", s), obsCount, 0);
      end
      rst_n = 1'b1;

      // overlapping 101 on 10101
      sel = 0;
      applyStimulus(1'b1, 8'b101, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t1 cfg armed", 32'(obsArmed), 0);
      sendBits(32'b10101, 5, 32'b00101, 32'b00111, "t1");
      checkOutput("t1 count", obsCount, 2);

      // non-overlapping 101 on 10101101
      applyStimulus(1'b1, 8'b101, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("t2 cleared count", obsCount, 0);
      sendBits(32'b10101101, 8, 32'b00100001, 32'b00000110, "t2");
      checkOutput("t2 count", obsCount, 2);

      // valid gaps do not break the sequence
      applyStimulus(1'b1, 8'b101, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 2; i >= 0; i--) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, t3Bits[i], 1'b0);
         checkOutput($sformatf("t3 match bit%0d", 3 - i), 32'(obsMatch), (i == 0) ? 1 : 0);
         if (i > 0) begin
            for (int g = 0; g < 2; g++) begin
               applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
               checkOutput("t3 match gap", 32'(obsMatch), 0);
            end
         end
      end
      checkOutput("t3 armed", 32'(obsArmed), 1);
      checkOutput("t3 count", obsCount, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3 idle match", 32'(obsMatch), 0);
      checkOutput("t3 idle armed", 32'(obsArmed), 1);

      // 8-bit pattern A5, then a cfg_load that swallows a valid bit
      sel = 1;
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      sendBits(32'hA5A5, 16, 32'h0101, 32'h01FF, "t4");
      checkOutput("t4 count", obsCount, 2);
      sendBits(32'b1010, 4, 32'b0000, 32'b1111, "t4b");
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("t4 cfg match", 32'(obsMatch), 0);
      checkOutput("t4 cfg armed", 32'(obsArmed), 0);
      sendBits(32'b0100101, 7, 32'b0, 32'b0, "t4c");
      checkOutput("t4 count kept", obsCount, 2);

      // 2-bit counter saturation and clear-vs-hit priority
      sel = 2;
      applyStimulus(1'b1, 8'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
         checkOutput($sformatf("t5 match bit%0d", i + 1), 32'(obsMatch), (i == 0) ? 0 : 1);
         checkOutput($sformatf("t5 count bit%0d", i + 1), obsCount, (i < 3) ? i : 3);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("t5 clr match", 32'(obsMatch), 1);
      checkOutput("t5 clr count", obsCount, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("t5 after clr count", obsCount, 1);

      // reset mid-sequence restores pattern 0 with overlap on
      sel = 0;
      applyStimulus(1'b1, 8'b101, 1'b1, 1'b0, 1'b0, 1'b0);
      sendBits(32'b10, 2, 32'b00, 32'b00, "t6");
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("t6 rst match", 32'(obsMatch), 0);
      checkOutput("t6 rst armed", 32'(obsArmed), 0);
      checkOutput("t6 rst count", obsCount, 0);
      rst_n = 1'b1;
      sendBits(32'b10000, 5, 32'b00011, 32'b00111, "t6b");
      checkOutput("t6 count", obsCount, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule : tb_seq_detector_param
